// File: rtl/fir_sched_pkg.sv
// Shared definitions for the FIR job scheduler: FSM states, completion status
// codes and default descriptor field widths.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_REPORT
  } state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_REJ = 2'b01;
  localparam logic [1:0] ST_TO  = 2'b10;

  localparam int JOB_ADDR_W = 10;
  localparam int JOB_ID_W   = 4;
  localparam int WD_W       = 16;

endpackage

// File: rtl/fir_job_fifo.sv
// Synchronous descriptor FIFO; a push while full is taken only when a pop
// frees a slot in the same cycle.
module fir_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_job_scheduler.sv
// Queues FIR job descriptors and runs them one at a time on the FIR engine,
// with per-job watchdog supervision and a completion record per job.
module fir_job_scheduler
  import fir_sched_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int ID_W          = JOB_ID_W,
  parameter int ADDR_W        = JOB_ADDR_W,
  parameter int TO_BASE       = 32,
  parameter int TO_PER_SAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_in_addr,
  input  logic [ADDR_W-1:0] job_out_addr,
  input  logic [ADDR_W-1:0] job_count,
  input  logic [ID_W-1:0]   job_id,
  output logic              fir_start,
  output logic [ADDR_W-1:0] fir_input_addr,
  output logic [ADDR_W-1:0] fir_output_addr,
  output logic [ADDR_W-1:0] fir_sample_count,
  input  logic              fir_done,
  output logic              fir_abort,
  output logic              cmp_valid,
  input  logic              cmp_ready,
  output logic [ID_W-1:0]   cmp_id,
  output logic [1:0]        cmp_status,
  output logic              busy,
  output logic [7:0]        ok_count,
  output logic [7:0]        err_count
);

  localparam int DW = 3 * ADDR_W + ID_W;
  localparam logic [ADDR_W:0] SPAN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_n;
  logic              full, empty, pop;
  logic              done_q, done_rise, job_bad;
  logic [DW-1:0]     head;
  logic [ADDR_W-1:0] head_in, head_out, head_cnt;
  logic [ID_W-1:0]   head_id;
  logic [ADDR_W:0]   end_in, end_out;
  logic [WD_W-1:0]   wd;

  function automatic logic [WD_W-1:0] wd_load(input logic [ADDR_W-1:0] cnt);
    logic [31:0] t;
    t = 32'(TO_BASE) + 32'(cnt) * 32'(TO_PER_SAMPLE);
    if (t[31:WD_W] != '0) return '1;
    return t[WD_W-1:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  fir_job_fifo #(.DEPTH(DEPTH), .WIDTH(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (job_valid & job_ready),
    .pop   (pop),
    .din   ({job_in_addr, job_out_addr, job_count, job_id}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign pop       = (state == S_IDLE) & ~empty;
  assign job_ready = ~full | pop;
  assign busy      = (state != S_IDLE) | ~empty;
  assign done_rise = fir_done & ~done_q;

  // Job window checks are done one bit wider so base+count==2^ADDR_W is legal.
  assign {head_in, head_out, head_cnt, head_id} = head;
  assign end_in  = {1'b0, head_in} + {1'b0, head_cnt};
  assign end_out = {1'b0, head_out} + {1'b0, head_cnt};
  assign job_bad = (head_cnt == '0) | (end_in > SPAN) | (end_out > SPAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    fir_start = 1'b0;
    fir_abort = 1'b0;
    cmp_valid = 1'b0;
    case (state)
      S_IDLE:   if (!empty) state_n = job_bad ? S_REPORT : S_LAUNCH;
      S_LAUNCH: begin
        fir_start = 1'b1;
        state_n   = S_RUN;
      end
      S_RUN: begin
        if (done_rise) begin
          state_n = S_REPORT;
        end else if (wd == '0) begin
          fir_abort = 1'b1;
          state_n   = S_REPORT;
        end
      end
      S_REPORT: begin
        cmp_valid = 1'b1;
        if (cmp_ready) state_n = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  // Config is latched only at a valid pop so it stays put for the whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q           <= 1'b0;
      wd               <= '0;
      fir_input_addr   <= '0;
      fir_output_addr  <= '0;
      fir_sample_count <= '0;
      cmp_id           <= '0;
      cmp_status       <= ST_OK;
      ok_count         <= '0;
      err_count        <= '0;
    end else begin
      done_q <= fir_done;
      if (pop) begin
        cmp_id <= head_id;
        if (job_bad) begin
          cmp_status <= ST_REJ;
        end else begin
          fir_input_addr   <= head_in;
          fir_output_addr  <= head_out;
          fir_sample_count <= head_cnt;
        end
      end
      if (state == S_LAUNCH) wd <= wd_load(fir_sample_count);
      if (state == S_RUN) begin
        if (done_rise)      cmp_status <= ST_OK;
        else if (wd == '0)  cmp_status <= ST_TO;
        else                wd <= wd - WD_W'(1);
      end
      if (cmp_valid && cmp_ready) begin
        if (cmp_status == ST_OK) ok_count  <= sat_inc(ok_count);
        else                     err_count <= sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_fir_job_scheduler.sv
// Randomized scoreboard bench for fir_job_scheduler with a behavioural FIR
// engine responder and a queue-based reference model of job outcomes.
module tb_fir_job_scheduler;

  logic       clk, rst;
  logic       job_valid, job_ready;
  logic [9:0] job_in_addr, job_out_addr, job_count;
  logic [3:0] job_id;
  logic       fir_start, fir_done, fir_abort;
  logic [9:0] fir_input_addr, fir_output_addr, fir_sample_count;
  logic       cmp_valid, cmp_ready;
  logic [3:0] cmp_id;
  logic [1:0] cmp_status;
  logic       busy;
  logic [7:0] ok_count, err_count;

  fir_job_scheduler dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_in_addr(job_in_addr), .job_out_addr(job_out_addr),
    .job_count(job_count), .job_id(job_id),
    .fir_start(fir_start), .fir_input_addr(fir_input_addr),
    .fir_output_addr(fir_output_addr), .fir_sample_count(fir_sample_count),
    .fir_done(fir_done), .fir_abort(fir_abort),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
    .cmp_id(cmp_id), .cmp_status(cmp_status),
    .busy(busy), .ok_count(ok_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    logic [9:0] in_a;
    logic [9:0] out_a;
    logic [9:0] cnt;
    bit         hang;
    int         delay;
  } eng_t;

  exp_t exp_q[$];
  eng_t eng_q[$];
  eng_t cur;
  int   checks = 0, errors = 0;
  int   exp_ok = 0, exp_err = 0;
  int   cyc = 0, starts = 0, start_cyc = 0, eng_left = 0;
  bit   eng_active = 0, hold_ready = 0, rand_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic bit job_ok(input int a_in, input int a_out, input int cnt);
    return (cnt != 0) && (a_in + cnt <= 1024) && (a_out + cnt <= 1024);
  endfunction

  function automatic int wd_allow(input int cnt);
    int t;
    t = 32 + cnt * 16;
    return (t > 65535) ? 65535 : t;
  endfunction

  // Offer one job and record its expected outcome once the DUT takes it.
  task automatic send(input logic [9:0] a_in, input logic [9:0] a_out, input logic [9:0] cnt,
                      input logic [3:0] id, input bit hang, input int delay);
    exp_t e;
    eng_t g;
    int   w;
    @(negedge clk);
    job_valid = 1'b1; job_in_addr = a_in; job_out_addr = a_out;
    job_count = cnt; job_id = id;
    w = 0;
    forever begin
      #1;
      if (job_ready) begin
        e.id = id;
        if (job_ok(int'(a_in), int'(a_out), int'(cnt))) begin
          e.st = hang ? 2'b10 : 2'b00;
          g.in_a = a_in; g.out_a = a_out; g.cnt = cnt; g.hang = hang; g.delay = delay;
          eng_q.push_back(g);
        end else begin
          e.st = 2'b01;
        end
        exp_q.push_back(e);
        @(negedge clk);
        job_valid = 1'b0;
        return;
      end
      @(negedge clk);
      w++;
      if (w > 3000) begin
        flag("job_accept_timeout");
        job_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= budget) flag("idle_timeout");
    check("ok_count_idle", ok_count, exp_ok);
    check("err_count_idle", err_count, exp_err);
  endtask

  // Behavioural engine: done level rises `delay` cycles after start, or never.
  initial begin
    fir_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) continue;
      if (fir_abort && !(eng_active && cur.hang)) flag("unexpected_abort");
      if (fir_start) begin
        starts++;
        if (eng_active) flag("start_overlap");
        if (eng_q.size() == 0) begin
          flag("unexpected_start");
        end else begin
          cur = eng_q.pop_front();
          check("start_cfg", {fir_input_addr, fir_output_addr, fir_sample_count},
                {cur.in_a, cur.out_a, cur.cnt});
          eng_active = 1'b1;
          start_cyc  = cyc;
          eng_left   = cur.delay;
          fir_done   = 1'b0;
        end
      end else if (eng_active) begin
        if (cur.hang) begin
          if (fir_abort) begin
            check("abort_delay", cyc - start_cyc, wd_allow(int'(cur.cnt)) + 1);
            check("abort_cfg", {fir_input_addr, fir_output_addr, fir_sample_count},
                  {cur.in_a, cur.out_a, cur.cnt});
            eng_active = 1'b0;
          end
        end else begin
          eng_left--;
          if (eng_left == 0) begin
            check("held_cfg", {fir_input_addr, fir_output_addr, fir_sample_count},
                  {cur.in_a, cur.out_a, cur.cnt});
            fir_done   = 1'b1;
            eng_active = 1'b0;
          end
        end
      end
    end
  end

  // Completion monitor / scoreboard; also drives cmp_ready.
  initial begin
    logic       prev_wait;
    logic [3:0] pid;
    logic [1:0] pst;
    exp_t       e;
    prev_wait = 1'b0; pid = '0; pst = '0;
    cmp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
        continue;
      end
      cmp_ready = hold_ready ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (prev_wait) check("cmp_stable", {cmp_valid, cmp_id, cmp_status}, {1'b1, pid, pst});
      if (cmp_valid && cmp_ready) begin
        check("ok_count", ok_count, exp_ok);
        check("err_count", err_count, exp_err);
        if (exp_q.size() == 0) begin
          flag("unexpected_completion");
        end else begin
          e = exp_q.pop_front();
          check("cmp_id", cmp_id, e.id);
          check("cmp_status", cmp_status, e.st);
          if (e.st == 2'b00) exp_ok  = (exp_ok  < 255) ? exp_ok  + 1 : 255;
          else               exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        prev_wait = 1'b0;
      end else begin
        prev_wait = cmp_valid;
        pid = cmp_id;
        pst = cmp_status;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_ready"}, job_ready, 1);
    check({tag, "_ctrl"}, {fir_start, fir_abort, cmp_valid, busy}, 0);
    check({tag, "_cfg"}, {fir_input_addr, fir_output_addr, fir_sample_count}, 0);
    check({tag, "_cmp"}, {cmp_id, cmp_status}, 0);
    check({tag, "_counts"}, {ok_count, err_count}, 0);
  endtask

  initial begin
    int s0, n;
    logic [9:0] a_in, a_out, cnt;
    rst = 1'b1; job_valid = 1'b0;
    job_in_addr = '0; job_out_addr = '0; job_count = '0; job_id = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single job
    send(10'h000, 10'h100, 10'd4, 4'd3, 0, 50);
    wait_idle(500);
    check("single_ok_count", ok_count, 1);

    // Fill the queue behind a long-running job
    send(10'h010, 10'h020, 10'd4, 4'd15, 0, 60);
    for (int i = 0; i < 4; i++) send(10'(i * 8), 10'h200, 10'd6, 4'(i), 0, 5);
    #1;
    check("full_job_ready", job_ready, 0);
    check("full_busy", busy, 1);
    send(10'h040, 10'h300, 10'd6, 4'd4, 0, 5);
    check("fifth_after_pop", exp_q.size(), 5);
    wait_idle(1000);

    // Rejected descriptors, including the address window boundary
    s0 = starts;
    send(10'h000, 10'h000, 10'd0, 4'd7, 0, 5);
    send(10'h3FE, 10'h000, 10'd4, 4'd8, 0, 5);
    wait_idle(200);
    check("reject_no_start", starts, s0);
    check("reject_err_count", err_count, 2);
    send(10'h3FC, 10'h3FC, 10'd4, 4'd9, 0, 5);
    wait_idle(200);

    // Engine hang then a normal job
    send(10'h000, 10'h200, 10'd2, 4'd5, 1, 0);
    send(10'h010, 10'h020, 10'd3, 4'd6, 0, 10);
    wait_idle(1000);

    // Completion held off by the host
    hold_ready = 1;
    send(10'h000, 10'h100, 10'd2, 4'd2, 0, 5);
    send(10'h080, 10'h180, 10'd2, 4'd11, 0, 5);
    n = 0;
    while (!cmp_valid && n < 300) begin @(negedge clk); #2; n++; end
    if (n >= 300) flag("hold_cmp_timeout");
    s0 = starts;
    repeat (20) @(negedge clk);
    #2;
    check("hold_no_start", starts, s0);
    check("hold_ok_count", ok_count, exp_ok);
    check("hold_valid", cmp_valid, 1);
    hold_ready = 0;
    wait_idle(500);

    // Randomized traffic
    rand_ready = 1;
    for (int j = 0; j < 40; j++) begin
      bit hang;
      cnt = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 20));
      a_in  = 10'($urandom_range(0, 1023));
      a_out = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) a_in  = 10'(1024 - int'(cnt) + $urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) a_out = 10'(1024 - int'(cnt) + $urandom_range(0, 1));
      hang = ($urandom_range(0, 7) == 0);
      send(a_in, a_out, cnt, 4'($urandom), hang, $urandom_range(2, 40));
    end
    wait_idle(20000);
    rand_ready = 0;

    // Reset in the middle of a run with another job queued
    s0 = starts;
    send(10'h000, 10'h000, 10'd8, 4'd1, 0, 100);
    send(10'h100, 10'h100, 10'd8, 4'd12, 0, 5);
    n = 0;
    while (starts == s0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) flag("reset_test_start_timeout");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    eng_q.delete();
    eng_active = 1'b0;
    fir_done = 1'b0;
    exp_ok = 0;
    exp_err = 0;
    @(negedge clk);
    rst = 1'b0;
    s0 = starts;
    repeat (150) @(negedge clk);
    #2;
    check("post_reset_idle", {busy, cmp_valid}, 0);
    check("post_reset_no_start", starts, s0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_job_scheduler.md
Name: fir_job_scheduler

Overview:
- Queues FIR filter job descriptors (input base, output base, sample count, job id) from a host and sequences them one at a time onto the single 5-tap FIR engine.
- Per job: start pulse, watchdog supervision, done detection, then a completion record back to the host.
- Sits between the host/control bus and the FIR engine's start/config/done interface; the engine's memory ports are not touched.

Parameters:
- DEPTH, 4, job queue entries (power of 2, ≥2).
- ID_W, 4, job id width.
- ADDR_W, 10, address/count width (memory is 2^ADDR_W bytes).
- TO_BASE, 32, watchdog fixed allowance in cycles.
- TO_PER_SAMPLE, 16, watchdog allowance per sample (engine needs 12).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- job_valid  in  1  host job offered
- job_ready  out  1  queue not full
- job_in_addr  in  ADDR_W  input sample base
- job_out_addr  in  ADDR_W  output base
- job_count  in  ADDR_W  samples to filter
- job_id  in  ID_W  host tag
- fir_start  out  1  one-cycle start pulse to engine
- fir_input_addr  out  ADDR_W  held config to engine
- fir_output_addr  out  ADDR_W  held config to engine
- fir_sample_count  out  ADDR_W  held config to engine
- fir_done  in  1  engine done level (set at end of job, cleared by next start)
- fir_abort  out  1  one-cycle engine reset pulse on timeout
- cmp_valid  out  1  completion record valid
- cmp_ready  in  1  host accepts completion
- cmp_id  out  ID_W  id of completed job
- cmp_status  out  2  00 ok, 01 rejected, 10 timeout
- busy  out  1  queue non-empty or FSM not IDLE
- ok_count  out  8  saturating count of ok jobs
- err_count  out  8  saturating count of rejected plus timed-out jobs

Behaviour:
- Reset (async): queue empty. FSM=IDLE. All outputs 0 except job_ready=1. Config outputs 0. Counters 0. done_q=0. A reset mid-job drops the queue and any pending completion; the engine is reset by the same rst.
- Queue: FIFO, push when job_valid&job_ready. Pop when FSM leaves IDLE with a job. Push and pop in the same cycle are both allowed when full. Pointers wrap modulo DEPTH; count is DEPTH+1 states wide.
- Validity check at pop: the job is rejected if job_count==0 or in_addr+count>2^ADDR_W or out_addr+count>2^ADDR_W (sums computed at ADDR_W+1 bits).
- done_q registers fir_done every cycle. done_rise = fir_done & ~done_q.
- FSM:
  - IDLE: when the queue is non-empty, pop. Invalid job → REPORT with status 01. Valid job → latch config into fir_* outputs and go to LAUNCH.
  - LAUNCH (1 cycle): fir_start=1. Load watchdog with TO_BASE + count*TO_PER_SAMPLE (16-bit, saturating). Go to RUN.
  - RUN: watchdog decrements each cycle. done_rise → REPORT with status 00. Watchdog reaches 0 without done_rise → fir_abort=1 for that cycle, then REPORT with status 10. If done_rise and expiry coincide, done wins.
  - REPORT: cmp_valid=1 with id/status stable until cmp_ready. On handshake, bump the matching counter (saturate at 255) and go to IDLE.
- Latency: queue push to fir_start is 2 cycles minimum (IDLE pop, then LAUNCH). done_rise to cmp_valid is 1 cycle.
- fir_* config is held stable from LAUNCH until the next pop; it never changes during RUN.
- fir_start is asserted only from IDLE→LAUNCH, so it never overlaps a running engine job.
- Back-to-back: the next job can pop in the cycle after the REPORT handshake. The engine is then in its idle state.
- busy = (FSM!=IDLE) | queue non-empty.

Decomposition:
- Package fir_sched_pkg holds the FSM state encoding, the cmp_status codes (ST_OK, ST_REJ, ST_TO), and the job descriptor field widths.
- One natural sub-module: fir_job_fifo, a synchronous FIFO with DEPTH and data width 3*ADDR_W+ID_W, exposing full, empty, push, pop and dout.

Test Plan:
- Single job (in 0x000, out 0x100, count 4, id 3) with a behavioural engine that raises done 50 cycles after start → exactly one fir_start pulse; config 0x000/0x100/4 held; cmp id=3 status 00; ok_count=1.
- Push 5 jobs with DEPTH=4 and cmp_ready tied 1 → job_ready drops after 4 accepted. The 5th is taken only after the first pop. All 5 complete in order with ids 0..4.
- job_count=0 (id 7), then in_addr=0x3FE with count 4 (id 8) → no fir_start; two completions with status 01; err_count=2.
- Engine never raises done, count 2 → fir_abort pulses after TO_BASE+32=64 cycles in RUN; cmp status 10; the next queued job launches normally.
- cmp_ready held 0 for 20 cycles during REPORT → cmp fields stable; no new fir_start; counter increments once on the handshake.
- Assert rst during RUN → all outputs return to reset values immediately; queue empty; no completion emitted afterwards.
